pac_move_ctrl: RTL and testbench

Parametrised tile-grid movement controller for the player sprite; successor to the combinational legal-move lookup.
- Holds a GRID_ROWS x GRID_COLS table of 4-bit legal-exit masks.
- Tracks sprite position as tile plus sub-tile pixel offset, advancing one pixel per step tick.
- Buffers a queued turn request, applies it only at a tile centre where legal, stops at walls, and optionally wraps through edge tunnels.
- Feeds the sprite renderer (xpos/ypos) and pellet/ghost logic (tile, tile_enter).

---
 rtl/pac_pkg.sv | 30 +++
 rtl/pac_move_ctrl_if.sv | 32 +++
 rtl/pac_legal_rom.sv | 28 ++
 rtl/pac_move_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pac_move_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pac_pkg.sv
// Shared direction encoding and helpers for the tile-grid movement controllers
// (player sprite and ghosts).
package pac_pkg;

  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } move_state_e;

  // L<->R and U<->D differ only in the low bit of the heading code.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // Bit of the legal-exit mask for a heading: L=3, R=2, U=1, D=0.
  function automatic logic [1:0] leg_idx(input logic [1:0] d);
    return ~d;
  endfunction

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pac_move_ctrl_if.sv
// Request/position bundle between the joystick/renderer side and the
// movement controller.
interface pac_move_ctrl_if #(
  parameter int COL_W = 3,
  parameter int ROW_W = 3
);

  logic             en;
  logic             l;
  logic             r;
  logic             u;
  logic             d;
  logic [9:0]       xpos;
  logic [9:0]       ypos;
  logic [COL_W-1:0] tile_col;
  logic [ROW_W-1:0] tile_row;
  logic [1:0]       dir;
  logic             moving;
  logic [3:0]       leg;
  logic             tile_enter;

  modport master (
    output en, l, r, u, d,
    input  xpos, ypos, tile_col, tile_row, dir, moving, leg, tile_enter
  );

  modport slave (
    input  en, l, r, u, d,
    output xpos, ypos, tile_col, tile_row, dir, moving, leg, tile_enter
  );

endinterface

// File: rtl/pac_legal_rom.sv
// Parametrised legal-exit table: (col,row) -> 4-bit mask {L,R,U,D}.
// Out-of-grid coordinates read as a fully walled tile.
module pac_legal_rom
  import pac_pkg::*;
#(
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 8,
  parameter int COL_W     = idx_w(GRID_COLS),
  parameter int ROW_W     = idx_w(GRID_ROWS),
  parameter logic [GRID_ROWS*GRID_COLS*4-1:0] LEGAL_INIT = '0
) (
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [3:0]       leg
);

  always_comb begin
    leg = 4'b0000;
    for (int rr = 0; rr < GRID_ROWS; rr++) begin
      for (int cc = 0; cc < GRID_COLS; cc++) begin
        if (row == ROW_W'(rr) && col == COL_W'(cc)) begin
          leg = LEGAL_INIT[4*(rr*GRID_COLS+cc) +: 4];
        end
      end
    end
  end

endmodule

// File: rtl/pac_move_ctrl.sv
// Player tile-grid movement controller: queued turns applied at tile centres,
// wall stops, instant reversal, optional edge tunnels, one pixel per step tick.
module pac_move_ctrl
  import pac_pkg::*;
#(
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 8,
  parameter int TILE_PX   = 60,
  parameter int ORIGIN_X  = 150,
  parameter int ORIGIN_Y  = 34,
  parameter int START_COL = 1,
  parameter int START_ROW = 1,
  parameter int STEP_DIV  = 4,
  parameter bit WRAP_EN   = 1'b1,
  parameter logic [GRID_ROWS*GRID_COLS*4-1:0] LEGAL_INIT = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pac_move_ctrl_if.slave io
);

  localparam int COL_W = idx_w(GRID_COLS);
  localparam int ROW_W = idx_w(GRID_ROWS);
  localparam int SUB_W = $clog2(TILE_PX);
  localparam int DIV_W = idx_w(STEP_DIV);

  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(TILE_PX / 2);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TILE_PX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_ROWS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [SUB_W-1:0] sub_x, sub_x_nxt;
  logic [SUB_W-1:0] sub_y, sub_y_nxt;
  logic [1:0]       dir, dir_nxt;
  move_state_e      state, state_nxt;
  logic [1:0]       pend_dir, pend_dir_nxt;
  logic             pend_v, pend_v_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             tile_enter, tile_enter_nxt;

  logic [3:0]       leg_raw;
  logic [3:0]       wall_mask;
  logic [3:0]       leg_eff;
  logic             req_any;
  logic [1:0]       req_dir;
  logic             pv_eff;
  logic [1:0]       pd_eff;
  logic             at_centre;
  logic             tick;
  logic             do_move;
  logic [1:0]       mv_dir;

  pac_legal_rom #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W),
    .LEGAL_INIT(LEGAL_INIT)
  ) u_legal_rom (
    .col(col),
    .row(row),
    .leg(leg_raw)
  );

  // Without tunnels, an exit off the grid edge is treated as a wall.
  always_comb begin
    wall_mask = 4'b1111;
    if (!WRAP_EN) begin
      if (col == '0)      wall_mask[3] = 1'b0;
      if (col == COL_LAST) wall_mask[2] = 1'b0;
      if (row == '0)      wall_mask[1] = 1'b0;
      if (row == ROW_LAST) wall_mask[0] = 1'b0;
    end
  end

  assign leg_eff = leg_raw & wall_mask;

  // A request arriving this cycle is seen by this cycle's tick (bypass).
  assign req_any   = io.l | io.r | io.u | io.d;
  assign req_dir   = io.l ? DIR_L : io.r ? DIR_R : io.u ? DIR_U : DIR_D;
  assign pv_eff    = req_any | pend_v;
  assign pd_eff    = req_any ? req_dir : pend_dir;
  assign at_centre = (sub_x == SUB_MID) && (sub_y == SUB_MID);
  assign tick      = io.en && (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    pend_dir_nxt = pd_eff;
    pend_v_nxt   = pv_eff;
    div_nxt      = div_cnt;
    do_move      = 1'b0;
    mv_dir       = dir;
    if (io.en) begin
      div_nxt = tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (at_centre) begin
          if (pv_eff && leg_eff[leg_idx(pd_eff)]) begin
            dir_nxt    = pd_eff;
            mv_dir     = pd_eff;
            pend_v_nxt = 1'b0;
            state_nxt  = ST_MOVE;
            do_move    = 1'b1;
          end else if (state == ST_MOVE && leg_eff[leg_idx(dir)]) begin
            do_move = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          // Between centres only a reversal can be honoured; turns wait.
          do_move = 1'b1;
          if (pv_eff && pd_eff == opposite(dir)) begin
            dir_nxt    = pd_eff;
            mv_dir     = pd_eff;
            pend_v_nxt = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    col_nxt   = col;
    row_nxt   = row;
    sub_x_nxt = sub_x;
    sub_y_nxt = sub_y;
    if (do_move) begin
      case (mv_dir)
        DIR_L: begin
          if (sub_x == '0) begin
            sub_x_nxt = SUB_LAST;
            col_nxt   = (col == '0) ? COL_LAST : col - 1'b1;
          end else begin
            sub_x_nxt = sub_x - 1'b1;
          end
        end
        DIR_R: begin
          if (sub_x == SUB_LAST) begin
            sub_x_nxt = '0;
            col_nxt   = (col == COL_LAST) ? '0 : col + 1'b1;
          end else begin
            sub_x_nxt = sub_x + 1'b1;
          end
        end
        DIR_U: begin
          if (sub_y == '0) begin
            sub_y_nxt = SUB_LAST;
            row_nxt   = (row == '0) ? ROW_LAST : row - 1'b1;
          end else begin
            sub_y_nxt = sub_y - 1'b1;
          end
        end
        default: begin
          if (sub_y == SUB_LAST) begin
            sub_y_nxt = '0;
            row_nxt   = (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            sub_y_nxt = sub_y + 1'b1;
          end
        end
      endcase
    end
  end

  assign tile_enter_nxt = do_move && (sub_x_nxt == SUB_MID) && (sub_y_nxt == SUB_MID);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= COL_W'(START_COL);
      row        <= ROW_W'(START_ROW);
      sub_x      <= SUB_MID;
      sub_y      <= SUB_MID;
      dir        <= DIR_L;
      state      <= ST_IDLE;
      pend_dir   <= DIR_L;
      pend_v     <= 1'b0;
      div_cnt    <= '0;
      tile_enter <= 1'b0;
    end else begin
      col        <= col_nxt;
      row        <= row_nxt;
      sub_x      <= sub_x_nxt;
      sub_y      <= sub_y_nxt;
      dir        <= dir_nxt;
      state      <= state_nxt;
      pend_dir   <= pend_dir_nxt;
      pend_v     <= pend_v_nxt;
      div_cnt    <= div_nxt;
      tile_enter <= tile_enter_nxt;
    end
  end

  assign io.xpos       = 10'(ORIGIN_X) + 10'(col) * 10'(TILE_PX) + 10'(sub_x);
  assign io.ypos       = 10'(ORIGIN_Y) + 10'(row) * 10'(TILE_PX) + 10'(sub_y);
  assign io.tile_col   = col;
  assign io.tile_row   = row;
  assign io.dir        = dir;
  assign io.moving     = (state == ST_MOVE);
  assign io.leg        = leg_eff;
  assign io.tile_enter = tile_enter;

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Scoreboard bench for pac_move_ctrl on a small 4-pixel-tile maze: stimulus
// queues expected values, a negedge monitor pops and compares them.
module tb_pac_move_ctrl;
  import pac_pkg::*;

  function automatic logic [255:0] build_leg();
    logic [255:0] v;
    v = '0;
    v[4*1 +: 4] = 4'b1001;              // (1,0) L,D
    v[4*2 +: 4] = 4'b1000;              // (2,0) L
    v[4*3 +: 4] = 4'b1000;              // (3,0) L
    for (int c = 0; c < 8; c++) v[4*(8+c) +: 4] = 4'b0100;  // row 1 R
    v[4*11 +: 4] = 4'b0110;             // (3,1) R,U
    return v;
  endfunction

  localparam logic [255:0] LEG = build_leg();

  typedef enum {F_X, F_Y, F_COL, F_ROW, F_DIR, F_MOV, F_TE} fld_e;
  typedef struct { fld_e f; int v; string nm; } chk_t;
  typedef struct { int x; int y; } te_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chk_t chk_q[$];
  te_t  te_q[$];
  int   checks = 0;
  int   errors = 0;
  chk_t cur;
  te_t  tcur;
  int   act;

  pac_move_ctrl_if #(.COL_W(3), .ROW_W(3)) io ();

  pac_move_ctrl #(
    .GRID_COLS(8), .GRID_ROWS(8), .TILE_PX(4), .ORIGIN_X(146), .ORIGIN_Y(34),
    .START_COL(1), .START_ROW(1), .STEP_DIV(1), .WRAP_EN(1'b1), .LEGAL_INIT(LEG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  function automatic int rd(input fld_e f);
    case (f)
      F_X:     return int'(io.xpos);
      F_Y:     return int'(io.ypos);
      F_COL:   return int'(io.tile_col);
      F_ROW:   return int'(io.tile_row);
      F_DIR:   return int'(io.dir);
      F_MOV:   return int'(io.moving);
      default: return int'(io.tile_enter);
    endcase
  endfunction

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      cur = chk_q.pop_front();
      act = rd(cur.f);
      checks++;
      if (act != cur.v) begin
        errors++;
        $display("FAIL %s: got %0d, expected %0d", cur.nm, act, cur.v);
      end
    end
    if (rst_n && io.tile_enter) begin
      checks++;
      if (te_q.size() == 0) begin
        errors++;
        $display("FAIL tile_enter_unexpected: pulse at x=%0d y=%0d, expected no pulse", io.xpos, io.ypos);
      end else begin
        tcur = te_q.pop_front();
        if (int'(io.xpos) != tcur.x || int'(io.ypos) != tcur.y) begin
          errors++;
          $display("FAIL tile_enter_pos: got (%0d,%0d), expected (%0d,%0d)", io.xpos, io.ypos, tcur.x, tcur.y);
        end
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want(input fld_e f, input int v, input string nm);
    chk_q.push_back('{f, v, nm});
  endtask

  task automatic want_xy(input int x, input int y, input string nm);
    want(F_X, x, {nm, ".x"});
    want(F_Y, y, {nm, ".y"});
  endtask

  task automatic want_te(input int x, input int y);
    te_q.push_back('{x, y});
  endtask

  initial begin
    io.en = 1'b1; io.l = 1'b0; io.r = 1'b0; io.u = 1'b0; io.d = 1'b0;
    rst_n = 1'b0;
    adv(3);
    rst_n = 1'b1;
    want_xy(152, 40, "reset");
    want(F_COL, 1, "reset.col"); want(F_ROW, 1, "reset.row");
    want(F_DIR, 0, "reset.dir"); want(F_MOV, 0, "reset.moving");
    want(F_TE, 0, "reset.tile_enter");

    // Start: r from centre of (1,1), cross into (2,1)
    io.r = 1'b1;
    adv(1); io.r = 1'b0;
    want(F_X, 153, "start.x1"); want(F_MOV, 1, "start.moving"); want(F_DIR, 1, "start.dir");
    want_te(156, 40);
    adv(1); want(F_X, 154, "start.x2"); want(F_COL, 2, "start.col2");
    adv(1); want(F_X, 155, "start.x3");
    adv(1); want(F_X, 156, "start.centre");

    // Queued turn: u one pixel before centre of (3,1)
    adv(3); want(F_X, 159, "turn.pre");
    io.u = 1'b1; want_te(160, 40);
    adv(1); io.u = 1'b0;
    want(F_X, 160, "turn.centre_x"); want(F_DIR, 1, "turn.dir_held");
    adv(1); want(F_DIR, 2, "turn.dir"); want_xy(160, 39, "turn.up1");
    want_te(160, 36);
    adv(2); want(F_ROW, 0, "turn.row0"); want(F_Y, 37, "turn.up3");
    adv(1); want(F_Y, 36, "turn.centre");

    // Wall stop at (3,0) heading U
    adv(1); want(F_MOV, 0, "wall.moving"); want_xy(160, 36, "wall.pos");
    adv(2); want_xy(160, 36, "wall.hold"); want(F_MOV, 0, "wall.moving2");

    // Leave L; d queued through (2,0) where D is illegal, taken at (1,0)
    io.l = 1'b1;
    adv(1); io.l = 1'b0;
    want(F_X, 159, "left.x1"); want(F_DIR, 0, "left.dir");
    adv(1);
    io.d = 1'b1;
    adv(1); io.d = 1'b0;
    want(F_X, 157, "left.x3"); want(F_COL, 2, "left.col2");
    want_te(156, 36);
    adv(2); want(F_X, 155, "queue.skip_x"); want(F_DIR, 0, "queue.skip_dir");
    want_te(152, 36);
    adv(4); want(F_DIR, 3, "queue.turn_dir"); want_xy(152, 37, "queue.down1");
    want_te(152, 40);
    adv(3); want_xy(152, 40, "queue.centre"); want(F_ROW, 1, "queue.row1");
    adv(1); want(F_MOV, 0, "queue.wall"); want(F_Y, 40, "queue.wall_y");

    // Run R along row 1, reverse at sub_x=3 of tile 5
    io.r = 1'b1;
    adv(1); io.r = 1'b0;
    want(F_X, 153, "resume.x");
    want_te(156, 40); want_te(160, 40); want_te(164, 40); want_te(168, 40);
    adv(16); want(F_X, 169, "rev.pre"); want(F_COL, 5, "rev.col");
    io.l = 1'b1; want_te(168, 40);
    adv(1); io.l = 1'b0;
    want(F_X, 168, "rev.x"); want(F_DIR, 0, "rev.dir");
    adv(1); want(F_MOV, 0, "rev.stop"); want(F_X, 168, "rev.hold");

    // Tunnel from col 7 to col 0
    io.r = 1'b1; want_te(172, 40); want_te(176, 40);
    adv(1); io.r = 1'b0;
    want(F_X, 169, "tunnel.start");
    adv(9); want(F_COL, 0, "wrap.col"); want(F_X, 146, "wrap.x");
    want_te(148, 40);
    adv(3); want(F_X, 149, "pause.pre");

    // Pause 10 clocks; an l latched during the pause reverses on resume
    io.en = 1'b0;
    adv(3); io.l = 1'b1;
    want(F_X, 149, "pause.x3"); want(F_MOV, 1, "pause.moving");
    adv(1); io.l = 1'b0;
    adv(6); want_xy(149, 40, "pause.x10");
    io.en = 1'b1; want_te(148, 40);
    adv(1); want(F_X, 148, "pause.latched_rev"); want(F_DIR, 0, "pause.dir");
    adv(1); want(F_MOV, 0, "pause.stop");

    // Reset mid-move with en low
    io.r = 1'b1;
    adv(1); io.r = 1'b0;
    want(F_X, 149, "rst.pre1");
    adv(1); want(F_X, 150, "rst.pre2"); want(F_COL, 1, "rst.col_pre");
    rst_n = 1'b0; io.en = 1'b0;
    adv(1); rst_n = 1'b1; io.en = 1'b1;
    want_xy(152, 40, "rst.pos");
    want(F_COL, 1, "rst.col"); want(F_ROW, 1, "rst.row");
    want(F_MOV, 0, "rst.moving"); want(F_DIR, 0, "rst.dir");
    adv(2); want(F_X, 152, "rst.idle_x"); want(F_MOV, 0, "rst.idle_moving");
    adv(2);

    checks++;
    if (te_q.size() != 0) begin
      errors++;
      $display("FAIL tile_enter_missing: %0d pulses outstanding, expected 0", te_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
